calc_display_driver: RTL and testbench
======================================

Name: calc_display_driver

Overview:
- Consumer end of the calculator result interface: takes the 14-bit result Y, the sign flag sinal and the display enable EN.
- Converts Y to four BCD digits with a sequential double-dabble engine.
- Drives a time-multiplexed 5-position active-low 7-segment display: four value digits plus a sign position.
- Sits between the calculator core and the board display pins.

Parameters:
- CLK_DIV, 50000: clk cycles per scan tick (digit dwell time); legal range ≥ 2.
- N_BITS, 14: width of Y.
- MAX_VAL, 9999: value clamp; Y > MAX_VAL is displayed as MAX_VAL.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Y  in  14  unsigned result magnitude.
- sinal  in  1  1 = negative result.
- EN  in  1  1 = display on.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- an  out  5  digit select, active-low, one-hot; an[0]=units … an[3]=thousands, an[4]=sign.
- bcd  out  16  latest converted digits; [3:0]=units … [15:12]=thousands.
- busy  out  1  high while the converter is in SHIFT or DONE.

Behaviour:
- Reset (asynchronous, takes effect immediately): seg=7'h7F, an=5'h1F, bcd=0, busy=0, FSM=IDLE, scan counter=0, digit index=0, captured sign=0. A conversion in progress is abandoned; no partial bcd is ever written.
- Converter FSM, which runs continuously:
  - IDLE (1 cycle): capture min(Y,MAX_VAL) and sinal; clear the shift count and the scratch BCD; go to SHIFT.
  - SHIFT (exactly 14 cycles): each cycle, first add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1; after the 14th shift go to DONE.
  - DONE (1 cycle): copy the scratch BCD to bcd and the captured sign to the display sign register; go to IDLE.
- Timing: period 16 cycles. bcd reflects the Y sampled 15 cycles before the DONE edge. Worst-case latency from a Y change to a bcd update is 31 cycles.
- Y changing during SHIFT is ignored; the next IDLE picks it up.
- Scan:
  - The tick counter counts 0..CLK_DIV-1. On reaching CLK_DIV-1 it wraps to 0 and the digit index advances 0→1→2→3→4→0.
  - an and seg are registered: they change on the clk edge after the index changes.
  - The scan runs even when EN=0.
- Digit content:
  - Positions 0–3 show the standard 0–9 glyphs.
  - Leading-zero blanking: position k (k≥1) shows blank (7'h7F) if it and all higher value digits are 0. Position 0 is never blanked, so value 0 shows "0".
  - Position 4 shows '-' (only g lit, 7'h3F) when the registered sign is 1 and bcd≠0; otherwise blank. A "-0" display is forbidden.
- EN=0: the next registered output is an=5'h1F and seg=7'h7F. Conversion continues, so re-enabling shows current data within one clk.
- Clamp: Y=16383 → bcd=16'h9999.

Decomposition:
- Package calc_display_pkg:
  - converter state enum {IDLE, SHIFT, DONE};
  - constants SEG_BLANK=7'h7F and SEG_MINUS=7'h3F;
  - 10-entry active-low glyph table;
  - N_POS=5.
- Sub-module bin2bcd_seq: the FSM and shift engine. Ports clk, rst_n, bin[13:0], sign_in → bcd[15:0], sign_out, busy.
- The top level holds the scan counter, blanking logic and output registers.

Test Plan (CLK_DIV=4):
- Reset mid-SHIFT (assert rst_n=0 for 3 cycles) → seg=7F, an=1F, bcd=0 immediately. After release, the first bcd update occurs exactly 16 cycles after the first IDLE.
- Y=9801, sinal=0, EN=1, run 40 cycles → bcd=16'h9801. The scan shows positions 0..3 as 1,0,8,9 and position 4 blank; each an value holds for 4 cycles, in order 1E,1D,1B,17,0F.
- Y=42, sinal=1 → bcd=16'h0042. Positions 2 and 3 blank, position 4 seg=3F ("-"), position 1 shows 4, position 0 shows 2.
- Y=0, sinal=1 → position 0 shows "0" (seg=7'h40), positions 1–4 all 7F; no minus sign.
- Y=14'h3FFF → bcd=16'h9999 (clamp).
- EN toggles 1→0→1 mid-scan → an=1F and seg=7F one clk after EN falls; bcd keeps updating; after EN rises, digits resume one clk later with the same index sequence.

Source files
------------

// File: rtl/calc_display_pkg.sv
// Shared types, glyph table and BCD helpers for the calculator display driver.
package calc_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam int         N_POS     = 5;

  // Active-low glyphs, bit order gfedcba.
  localparam logic [6:0] GLYPH [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] glyph_of(input logic [3:0] digit);
    logic [6:0] g;
    if (digit <= 4'd9) begin
      g = GLYPH[digit];
    end else begin
      g = SEG_BLANK;
    end
    return g;
  endfunction

  function automatic logic [15:0] add3_all(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running double-dabble converter: one IDLE capture, N_BITS shifts, one DONE
// publish, so a new bcd/sign pair appears every N_BITS+2 cycles.
module bin2bcd_seq
  import calc_display_pkg::*;
#(
  parameter int N_BITS  = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BITS-1:0] bin,
  input  logic              sign_in,
  output logic [15:0]       bcd,
  output logic              sign_out,
  output logic              busy
);

  localparam int CNT_W = $clog2(N_BITS);

  conv_state_t       state_r;
  logic [N_BITS-1:0] bin_r;
  logic [15:0]       scratch_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              sign_cap_r;
  logic [15:0]       bcd_r;
  logic              sign_out_r;
  logic              busy_r;

  logic [N_BITS-1:0] clamp_s;
  logic [15:0]       adj_s;
  logic [15:0]       shift_bcd_s;
  logic [N_BITS-1:0] shift_bin_s;

  // Clamp the input and form one add-3-then-shift step.
  always_comb begin
    if (bin > N_BITS'(MAX_VAL)) begin
      clamp_s = N_BITS'(MAX_VAL);
    end else begin
      clamp_s = bin;
    end
    adj_s       = add3_all(scratch_r);
    shift_bcd_s = {adj_s[14:0], bin_r[N_BITS-1]};
    shift_bin_s = {bin_r[N_BITS-2:0], 1'b0};
  end

  // Converter FSM; bcd is only written in DONE so a reset never leaves partial digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      bin_r      <= '0;
      scratch_r  <= 16'h0000;
      cnt_r      <= '0;
      sign_cap_r <= 1'b0;
      bcd_r      <= 16'h0000;
      sign_out_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bin_r      <= clamp_s;
          sign_cap_r <= sign_in;
          scratch_r  <= 16'h0000;
          cnt_r      <= '0;
          state_r    <= SHIFT;
          busy_r     <= 1'b1;
        end
        SHIFT: begin
          scratch_r <= shift_bcd_s;
          bin_r     <= shift_bin_s;
          cnt_r     <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(N_BITS - 1)) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          bcd_r      <= scratch_r;
          sign_out_r <= sign_cap_r;
          state_r    <= IDLE;
          busy_r     <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd      = bcd_r;
  assign sign_out = sign_out_r;
  assign busy     = busy_r;

endmodule

// File: rtl/calc_display_driver.sv
// Result display driver: BCD conversion plus a 5-position multiplexed active-low
// 7-segment scan with leading-zero blanking and a sign position.
module calc_display_driver
  import calc_display_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int N_BITS  = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BITS-1:0] Y,
  input  logic              sinal,
  input  logic              EN,
  output logic [6:0]        seg,
  output logic [4:0]        an,
  output logic [15:0]       bcd,
  output logic              busy
);

  localparam int TICK_W = $clog2(CLK_DIV);

  logic [TICK_W-1:0] tick_r;
  logic [2:0]        idx_r;
  logic [6:0]        seg_r;
  logic [4:0]        an_r;

  logic [15:0] bcd_s;
  logic        sign_s;
  logic        busy_s;
  logic [6:0]  seg_v_s;
  logic [4:0]  an_v_s;
  logic [6:0]  seg_nxt_s;
  logic [4:0]  an_nxt_s;

  bin2bcd_seq #(
    .N_BITS  (N_BITS),
    .MAX_VAL (MAX_VAL)
  ) u_conv (
    .clk      (clk),
    .rst_n    (rst_n),
    .bin      (Y),
    .sign_in  (sinal),
    .bcd      (bcd_s),
    .sign_out (sign_s),
    .busy     (busy_s)
  );

  // Glyph and digit select for the current scan position, with blanking.
  always_comb begin
    seg_v_s = SEG_BLANK;
    an_v_s  = 5'h1F;
    case (idx_r)
      3'd0: begin
        seg_v_s = glyph_of(bcd_s[3:0]);
        an_v_s  = 5'h1E;
      end
      3'd1: begin
        seg_v_s = (bcd_s[15:4] == 12'h000) ? SEG_BLANK : glyph_of(bcd_s[7:4]);
        an_v_s  = 5'h1D;
      end
      3'd2: begin
        seg_v_s = (bcd_s[15:8] == 8'h00) ? SEG_BLANK : glyph_of(bcd_s[11:8]);
        an_v_s  = 5'h1B;
      end
      3'd3: begin
        seg_v_s = (bcd_s[15:12] == 4'h0) ? SEG_BLANK : glyph_of(bcd_s[15:12]);
        an_v_s  = 5'h17;
      end
      3'd4: begin
        // A zero value never shows a minus sign.
        seg_v_s = (sign_s && (bcd_s != 16'h0000)) ? SEG_MINUS : SEG_BLANK;
        an_v_s  = 5'h0F;
      end
      default: begin
        seg_v_s = SEG_BLANK;
        an_v_s  = 5'h1F;
      end
    endcase
    if (EN) begin
      seg_nxt_s = seg_v_s;
      an_nxt_s  = an_v_s;
    end else begin
      seg_nxt_s = SEG_BLANK;
      an_nxt_s  = 5'h1F;
    end
  end

  // Scan tick counter, digit index and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_r <= '0;
      idx_r  <= 3'd0;
      seg_r  <= SEG_BLANK;
      an_r   <= 5'h1F;
    end else begin
      if (tick_r == TICK_W'(CLK_DIV - 1)) begin
        tick_r <= '0;
        idx_r  <= (idx_r == 3'(N_POS - 1)) ? 3'd0 : idx_r + 3'd1;
      end else begin
        tick_r <= tick_r + TICK_W'(1);
      end
      seg_r <= seg_nxt_s;
      an_r  <= an_nxt_s;
    end
  end

  assign seg  = seg_r;
  assign an   = an_r;
  assign bcd  = bcd_s;
  assign busy = busy_s;

endmodule

// File: tb/tb_calc_display_driver.sv
// Directed, table-driven bench for calc_display_driver with CLK_DIV=4.
module tb_calc_display_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] Y;
  logic        sinal;
  logic        EN;
  logic [6:0]  seg;
  logic [4:0]  an;
  logic [15:0] bcd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  calc_display_driver #(.CLK_DIV(4), .N_BITS(14), .MAX_VAL(9999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Y     (Y),
    .sinal (sinal),
    .EN    (EN),
    .seg   (seg),
    .an    (an),
    .bcd   (bcd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0]      y;
    logic             s;
    logic [15:0]      bcd;
    logic [4:0][6:0]  segs;   // [p] = expected glyph at scan position p
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pos_of(input logic [4:0] a);
    case (a)
      5'h1E:   return 0;
      5'h1D:   return 1;
      5'h1B:   return 2;
      5'h17:   return 3;
      5'h0F:   return 4;
      default: return -1;
    endcase
  endfunction

  // Observe the scan for 30 cycles and check every displayed position's glyph.
  task automatic scan_check(input vec_t v, input string nm);
    logic [4:0] seen;
    int p;
    seen = 5'h00;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      p = pos_of(an);
      chk({nm, " an_onehot"}, (p >= 0) ? 32'd1 : 32'd0, 32'd1);
      if (p >= 0) begin
        chk($sformatf("%s seg_pos%0d", nm, p), {25'd0, seg}, {25'd0, v.segs[p]});
        seen[p] = 1'b1;
      end
    end
    chk({nm, " all_positions"}, {27'd0, seen}, 32'h1F);
  endtask

  // Count edges from reset release to the first bcd publish.
  task automatic first_update(input logic [15:0] exp_bcd, input string nm);
    repeat (15) @(negedge clk);
    chk({nm, " bcd_before"}, {16'd0, bcd}, 32'h0);
    chk({nm, " busy_in_done"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk({nm, " bcd_at_16"}, {16'd0, bcd}, {16'd0, exp_bcd});
    chk({nm, " busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int prev_p;
    int p;
    logic found;
    logic [4:0] prev_an;

    vecs[0] = '{14'd9801,  1'b0, 16'h9801, {7'h7F, 7'h10, 7'h00, 7'h40, 7'h79}};
    vecs[1] = '{14'd42,    1'b1, 16'h0042, {7'h3F, 7'h7F, 7'h7F, 7'h19, 7'h24}};
    vecs[2] = '{14'd0,     1'b1, 16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{14'h3FFF,  1'b0, 16'h9999, {7'h7F, 7'h10, 7'h10, 7'h10, 7'h10}};
    vecs[4] = '{14'h3FFF,  1'b1, 16'h9999, {7'h3F, 7'h10, 7'h10, 7'h10, 7'h10}};
    vecs[5] = '{14'd10000, 1'b0, 16'h9999, {7'h7F, 7'h10, 7'h10, 7'h10, 7'h10}};
    vecs[6] = '{14'd305,   1'b1, 16'h0305, {7'h3F, 7'h7F, 7'h30, 7'h40, 7'h12}};
    vecs[7] = '{14'd7,     1'b0, 16'h0007, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}};

    rst_n = 1'b0;
    Y     = 14'd9801;
    sinal = 1'b0;
    EN    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset seg", {25'd0, seg}, 32'h7F);
    chk("reset an", {27'd0, an}, 32'h1F);
    chk("reset bcd", {16'd0, bcd}, 32'h0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    first_update(16'h9801, "first");

    // Dwell and ordering of the digit select for 9801.
    found   = 1'b0;
    prev_an = an;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (an == 5'h1E && prev_an != 5'h1E) found = 1'b1;
      prev_an = an;
    end
    chk("scan start found", {31'd0, found}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("an order k%0d", k), {27'd0, an}, {27'd0, ~(5'd1 << (k / 4))});
    end

    // Table-driven value/glyph checks.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      Y     = vecs[i].y;
      sinal = vecs[i].s;
      repeat (40) @(negedge clk);
      chk($sformatf("vec%0d bcd", i), {16'd0, bcd}, {16'd0, vecs[i].bcd});
      scan_check(vecs[i], $sformatf("vec%0d", i));
    end

    // EN toggle mid-scan: blank one clk after fall, conversion keeps running.
    Y = 14'd9801; sinal = 1'b0;
    repeat (40) @(negedge clk);
    repeat (2) @(negedge clk);
    EN = 1'b0;
    @(negedge clk);
    chk("en_off an", {27'd0, an}, 32'h1F);
    chk("en_off seg", {25'd0, seg}, 32'h7F);
    Y = 14'd42; sinal = 1'b1;
    repeat (40) @(negedge clk);
    chk("en_off bcd updates", {16'd0, bcd}, 32'h0042);
    chk("en_off still blank", {27'd0, an}, 32'h1F);
    EN = 1'b1;
    @(negedge clk);
    prev_p = pos_of(an);
    chk("en_on an_onehot", (prev_p >= 0) ? 32'd1 : 32'd0, 32'd1);
    if (prev_p >= 0) chk("en_on seg", {25'd0, seg}, {25'd0, vecs[1].segs[prev_p]});
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      p = pos_of(an);
      if (p != prev_p) begin
        found = 1'b1;
        chk("en_on next index", p, (prev_p + 1) % 5);
      end
    end
    chk("en_on advance seen", {31'd0, found}, 32'd1);

    // Reset asserted mid-SHIFT takes effect without a clock edge.
    Y = 14'd305; sinal = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (busy) found = 1'b1;
    end
    chk("busy seen", {31'd0, found}, 32'd1);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset seg", {25'd0, seg}, 32'h7F);
    chk("midreset an", {27'd0, an}, 32'h1F);
    chk("midreset bcd", {16'd0, bcd}, 32'h0);
    chk("midreset busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    first_update(16'h0305, "postreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
